// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow sequencer.
package game_pkg;

   typedef enum logic [2:0] {
      StHalted,
      StMainMenu,
      StPlay,
      StPaused,
      StLevelClear,
      StGameOver,
      StVictory
   } game_state_t;

   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_ESC   = 8'h29;

   // One-hot map select; callers size-cast the result to their map count (at most 32).
   function automatic logic [31:0] map_onehot(input int unsigned idx);
      map_onehot = 32'd1 << idx;
   endfunction

endpackage

// File: rtl/game_flow_ctrl_key_edge.sv
// Rising-edge detector for one keycode across all packed keyboard slots.
module key_edge #(
   parameter int unsigned KEY_SLOTS = 2,
   parameter logic [7:0]  KEY       = 8'h28
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [8*KEY_SLOTS-1:0] keycode,
   input  logic                   load_halt,
   output logic                   ev
);

   logic hit;
   logic prev_q;

   // Key is pressed if any slot carries it.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < KEY_SLOTS; i++) begin
         if (keycode[8*i +: 8] == KEY) hit = 1'b1;
      end
   end

   // Previous-press register; it also tracks the key while halted so a key held through
   // reset is already seen as "old" by the first menu cycle.
   always_ff @(posedge Clk) begin
      if (Reset) prev_q <= 1'b0;
      else       prev_q <= hit;
   end

   // No event is reported while halted.
   assign ev = hit & ~prev_q & ~load_halt;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: menu, play, pause, level-clear banner, game over and victory.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int unsigned NUM_MAPS     = 3,
   parameter int unsigned KEY_SLOTS    = 2,
   parameter logic [7:0]  KEY_START    = KEY_ENTER,
   parameter logic [7:0]  KEY_PAUSE    = KEY_ESC,
   parameter int unsigned CLEAR_FRAMES = 120,
   localparam int unsigned MAP_W       = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [8*KEY_SLOTS-1:0] keycode,
   input  logic                   frame_tick,
   input  logic                   level_done,
   input  logic                   player_dead,
   output logic                   LD_MENU,
   output logic [NUM_MAPS-1:0]    LD_Map,
   output logic [MAP_W-1:0]       map_idx,
   output logic                   map_start,
   output logic                   Pause_En,
   output logic                   game_over,
   output logic                   victory
);

   localparam int unsigned CNT_W = $clog2(CLEAR_FRAMES + 1);

   game_state_t      state_q, state_d;
   logic [MAP_W-1:0] map_idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ev_start, ev_pause;
   logic             halted;

   assign halted = (state_q == StHalted);

   key_edge #(
      .KEY_SLOTS (KEY_SLOTS),
      .KEY       (KEY_START)
   ) u_edge_start (
      .Clk       (Clk),
      .Reset     (Reset),
      .keycode   (keycode),
      .load_halt (halted),
      .ev        (ev_start)
   );

   key_edge #(
      .KEY_SLOTS (KEY_SLOTS),
      .KEY       (KEY_PAUSE)
   ) u_edge_pause (
      .Clk       (Clk),
      .Reset     (Reset),
      .keycode   (keycode),
      .load_halt (halted),
      .ev        (ev_pause)
   );

   // Next state, map index and banner counter.
   always_comb begin
      state_d   = state_q;
      map_idx_d = map_idx;
      cnt_d     = cnt_q;
      case (state_q)
         StHalted: state_d = StMainMenu;
         StMainMenu: begin
            if (ev_start) begin
               state_d   = StPlay;
               map_idx_d = '0;
            end
         end
         StPlay: begin
            if (player_dead) begin
               state_d = StGameOver;
            end else if (level_done) begin
               state_d = StLevelClear;
               cnt_d   = '0;
            end else if (ev_pause) begin
               state_d = StPaused;
            end
         end
         StPaused: begin
            if (ev_pause) state_d = StPlay;
         end
         StLevelClear: begin
            if (frame_tick) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(CLEAR_FRAMES - 1)) begin
                  if (map_idx == MAP_W'(NUM_MAPS - 1)) begin
                     state_d = StVictory;
                  end else begin
                     map_idx_d = map_idx + 1'b1;
                     state_d   = StPlay;
                  end
               end
            end
         end
         StGameOver, StVictory: begin
            if (ev_start) state_d = StMainMenu;
         end
         default: state_d = StHalted;
      endcase
   end

   // State register with outputs registered from the next state, so they track state_q.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= StHalted;
         map_idx   <= '0;
         cnt_q     <= '0;
         LD_MENU   <= 1'b0;
         LD_Map    <= '0;
         map_start <= 1'b0;
         Pause_En  <= 1'b0;
         game_over <= 1'b0;
         victory   <= 1'b0;
      end else begin
         state_q   <= state_d;
         map_idx   <= map_idx_d;
         cnt_q     <= cnt_d;
         LD_MENU   <= (state_d == StMainMenu);
         LD_Map    <= (state_d == StPlay || state_d == StPaused || state_d == StLevelClear)
                      ? NUM_MAPS'(map_onehot(32'(map_idx_d))) : '0;
         // Resuming from pause is not a map start.
         map_start <= (state_d == StPlay) &&
                      (state_q == StMainMenu || state_q == StLevelClear);
         Pause_En  <= (state_d == StPaused || state_d == StLevelClear);
         game_over <= (state_d == StGameOver);
         victory   <= (state_d == StVictory);
      end
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl (3 maps, 2 key slots, 4-frame banner).
module tb_game_flow_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] keycode = 16'h0000;
   logic        frame_tick = 1'b0;
   logic        level_done = 1'b0;
   logic        player_dead = 1'b0;
   logic        LD_MENU;
   logic [2:0]  LD_Map;
   logic [1:0]  map_idx;
   logic        map_start;
   logic        Pause_En;
   logic        game_over;
   logic        victory;

   int passed = 0;
   int total  = 0;

   game_flow_ctrl #(
      .NUM_MAPS     (3),
      .KEY_SLOTS    (2),
      .KEY_START    (8'h28),
      .KEY_PAUSE    (8'h29),
      .CLEAR_FRAMES (4)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .keycode     (keycode),
      .frame_tick  (frame_tick),
      .level_done  (level_done),
      .player_dead (player_dead),
      .LD_MENU     (LD_MENU),
      .LD_Map      (LD_Map),
      .map_idx     (map_idx),
      .map_start   (map_start),
      .Pause_En    (Pause_En),
      .game_over   (game_over),
      .victory     (victory)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
   endtask

   // Reference model: game phases as names, map number and banner frames as integers.
   string m_mode = "HALTED";
   int    m_map = 0;
   int    m_frames = 0;
   bit    m_held_s = 0, m_held_p = 0, m_pulse = 0, m_valid = 0;

   always @(posedge Clk) begin
      bit    hs, hp, es, ep;
      string old;
      if (Reset) begin
         m_mode = "HALTED"; m_map = 0; m_frames = 0;
         m_held_s = 0; m_held_p = 0; m_pulse = 0; m_valid = 1;
      end else begin
         hs = (keycode[7:0] == 8'h28) || (keycode[15:8] == 8'h28);
         hp = (keycode[7:0] == 8'h29) || (keycode[15:8] == 8'h29);
         es = hs && !m_held_s;
         ep = hp && !m_held_p;
         old = m_mode;
         if (m_mode == "HALTED") m_mode = "MENU";
         else if (m_mode == "MENU") begin
            if (es) begin m_mode = "PLAY"; m_map = 0; end
         end else if (m_mode == "PLAY") begin
            if (player_dead) m_mode = "OVER";
            else if (level_done) begin m_mode = "CLEAR"; m_frames = 0; end
            else if (ep) m_mode = "PAUSED";
         end else if (m_mode == "PAUSED") begin
            if (ep) m_mode = "PLAY";
         end else if (m_mode == "CLEAR") begin
            if (frame_tick) begin
               m_frames++;
               if (m_frames == 4) begin
                  if (m_map == 2) m_mode = "WIN";
                  else begin m_map++; m_mode = "PLAY"; end
               end
            end
         end else if (es) m_mode = "MENU";
         m_pulse = (m_mode == "PLAY") && (old == "MENU" || old == "CLEAR");
         m_held_s = hs;
         m_held_p = hp;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge Clk) begin
      bit in_map;
      if (m_valid) begin
         in_map = (m_mode == "PLAY" || m_mode == "PAUSED" || m_mode == "CLEAR");
         check("LD_MENU", 32'(LD_MENU), 32'(m_mode == "MENU"));
         check("LD_Map", 32'(LD_Map), in_map ? (32'd1 << m_map) : 32'd0);
         check("map_idx", 32'(map_idx), 32'(m_map));
         check("map_start", 32'(map_start), 32'(m_pulse));
         check("Pause_En", 32'(Pause_En), 32'(m_mode == "PAUSED" || m_mode == "CLEAR"));
         check("game_over", 32'(game_over), 32'(m_mode == "OVER"));
         check("victory", 32'(victory), 32'(m_mode == "WIN"));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic clear_level();
      level_done = 1'b1; tick(1); level_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         frame_tick = 1'b1; tick(1); frame_tick = 1'b0; tick(1);
      end
   endtask

   initial begin
      tick(2);
      Reset = 1'b0;
      tick(2);
      check("menu_after_reset", 32'(LD_MENU), 32'd1);
      check("menu_ld_map", 32'(LD_Map), 32'd0);
      check("menu_pause", 32'(Pause_En), 32'd0);

      // Enter held in slot 1 for 10 cycles: one start.
      keycode = 16'h2800;
      tick(1);
      check("start_pulse", 32'(map_start), 32'd1);
      check("start_map0", 32'(LD_Map), 32'b001);
      tick(1);
      check("start_pulse_once", 32'(map_start), 32'd0);
      tick(8);
      check("held_stays_play", 32'(LD_MENU), 32'd0);
      keycode = 16'h0000;
      tick(1);

      // Enter held through reset must not start the game.
      keycode = 16'h0028; Reset = 1'b1;
      tick(1);
      check("halted_menu", 32'(LD_MENU), 32'd0);
      check("halted_map", 32'(LD_Map), 32'd0);
      Reset = 1'b0;
      tick(4);
      check("held_reset_menu", 32'(LD_MENU), 32'd1);
      keycode = 16'h0000; tick(1);
      keycode = 16'h0028; tick(1);
      check("restart_pulse", 32'(map_start), 32'd1);
      keycode = 16'h0000; tick(2);

      // Pause, death ignored while paused, resume.
      keycode = 16'h0029; tick(1);
      check("paused", 32'(Pause_En), 32'd1);
      keycode = 16'h0000; player_dead = 1'b1; tick(3);
      check("dead_ignored", 32'(game_over), 32'd0);
      player_dead = 1'b0;
      keycode = 16'h2900; tick(1);
      check("resumed", 32'(Pause_En), 32'd0);
      check("resume_no_pulse", 32'(map_start), 32'd0);
      keycode = 16'h0000; tick(1);

      // Map 0 banner; death during a frame tick is ignored.
      level_done = 1'b1; tick(1); level_done = 1'b0;
      check("clear_pause", 32'(Pause_En), 32'd1);
      for (int i = 0; i < 4; i++) begin
         frame_tick = 1'b1; player_dead = (i == 0); tick(1);
         frame_tick = 1'b0; player_dead = 1'b0;
         if (i == 2) check("banner_3_ticks", 32'(Pause_En), 32'd1);
         if (i == 3) begin
            check("next_map_idx", 32'(map_idx), 32'd1);
            check("next_map_ld", 32'(LD_Map), 32'b010);
            check("next_map_pulse", 32'(map_start), 32'd1);
         end
         tick(1);
      end

      clear_level();
      check("map2_ld", 32'(LD_Map), 32'b100);
      clear_level();
      check("victory", 32'(victory), 32'd1);
      check("victory_ld_map", 32'(LD_Map), 32'd0);
      keycode = 16'h0028; tick(1);
      check("victory_to_menu", 32'(LD_MENU), 32'd1);
      check("map_idx_retained", 32'(map_idx), 32'd2);
      keycode = 16'h0000; tick(1);
      keycode = 16'h0028; tick(1);
      check("replay_map0", 32'(map_idx), 32'd0);
      check("replay_ld", 32'(LD_Map), 32'b001);
      keycode = 16'h0000; tick(1);

      // Death wins over level_done; reset from game over.
      level_done = 1'b1; player_dead = 1'b1; tick(1);
      level_done = 1'b0; player_dead = 1'b0;
      check("dead_priority", 32'(game_over), 32'd1);
      Reset = 1'b1; tick(1);
      check("reset_game_over", 32'(game_over), 32'd0);
      check("reset_map_idx", 32'(map_idx), 32'd0);
      Reset = 1'b0; tick(1);
      check("back_to_menu", 32'(LD_MENU), 32'd1);

      // Start and pause together: menu only sees start.
      keycode = 16'h2928; tick(1);
      check("start_and_pause", 32'(map_start), 32'd1);
      tick(2);
      check("held_both_play", 32'(Pause_En), 32'd0);
      keycode = 16'h0000; tick(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game-flow sequencer and parametrised successor to the single-map menu controller. It decodes USB keycodes from the keyboard interface into edge-detected key events, and walks the game through menu, play, pause, level-clear, game-over and victory. It drives the map loader (one-hot map select), the menu loader and the pause gate consumed by the sprite/physics logic.

## Interface
Parameters:
- NUM_MAPS, 3: number of playable maps; minimum 1.
- KEY_SLOTS, 2: number of 8-bit keycode slots packed in `keycode`.
- KEY_START, 8'h28: Enter; starts the game and returns from end screens.
- KEY_PAUSE, 8'h29: Escape; toggles pause.
- CLEAR_FRAMES, 120: frame ticks spent in the level-clear banner; minimum 1.

Ports:
- Clk, input, 1: system clock. One clock; reset is synchronous and active-high.
- Reset, input, 1: synchronous, active-high.
- keycode, input, 8*KEY_SLOTS: current pressed keys; slot i is `[8i+7:8i]`; 8'h00 means empty.
- frame_tick, input, 1: one-cycle pulse per video frame (vsync-derived).
- level_done, input, 1: level goal reached; level-sensitive, sampled only in PLAY.
- player_dead, input, 1: player died; level-sensitive, sampled only in PLAY.
- LD_MENU, output, 1: show/load the main menu.
- LD_Map, output, NUM_MAPS: one-hot active map; all zero outside PLAY/PAUSED/LEVEL_CLEAR.
- map_idx, output, MAP_W = max(1, clog2(NUM_MAPS)): current map index.
- map_start, output, 1: one-cycle pulse on entry to PLAY from MAIN_MENU or LEVEL_CLEAR (not from PAUSED).
- Pause_En, output, 1: freeze gameplay; high in PAUSED and LEVEL_CLEAR.
- game_over, output, 1: high in GAME_OVER.
- victory, output, 1: high in VICTORY.

## Operation
- Key detect: `hit_X` = any slot equals KEY_X. Register `hit_X` as `prev_X`. Event `ev_X` = `hit_X & ~prev_X`. Holding a key produces exactly one event.
- States: HALTED, MAIN_MENU, PLAY, PAUSED, LEVEL_CLEAR, GAME_OVER, VICTORY.
- HALTED -> MAIN_MENU unconditionally.
- MAIN_MENU: on `ev_START`, clear map_idx to 0 and go to PLAY.
- PLAY: priority `player_dead` > `level_done` > `ev_PAUSE`.
  - `player_dead` -> GAME_OVER.
  - `level_done` -> LEVEL_CLEAR, with the frame counter cleared.
  - `ev_PAUSE` -> PAUSED.
- PAUSED: `ev_PAUSE` -> PLAY. `level_done` and `player_dead` are ignored.
- LEVEL_CLEAR: the counter increments on each `frame_tick`. On the tick that brings the count to CLEAR_FRAMES:
  - if map_idx == NUM_MAPS-1, go to VICTORY;
  - otherwise increment map_idx and go to PLAY.
- GAME_OVER / VICTORY: `ev_START` -> MAIN_MENU. map_idx is retained until the next MAIN_MENU start.
- Outputs are Moore decodes of the state register, except map_start, which is a registered entry pulse.
- map_idx never exceeds NUM_MAPS-1.
- Frame counter width is clog2(CLEAR_FRAMES+1). It is not advanced outside LEVEL_CLEAR.

## Timing
- Reset values:
  - State = HALTED; map_idx = 0; counter = 0; prev_* = 0.
  - All outputs 0, including LD_Map = 0.
  - Reset overrides every input in the same cycle.
- Latency:
  - Key press at edge N: event in cycle N, new state visible after edge N+1.
  - map_start is high for exactly the first cycle in PLAY.
- Reset mid-game: the next cycle is HALTED and the cycle after is MAIN_MENU, regardless of held keys.
- A key held through Reset does not generate an event in MAIN_MENU: prev_* is 0 after reset, so the first cycle counts it as an edge. To prevent this, prev_* is loaded with `hit_*` in HALTED.
- START and PAUSE events in the same cycle: each state consults only its own key.
- `frame_tick` together with `player_dead` in LEVEL_CLEAR: `player_dead` is ignored.

## Structure
- Package `game_pkg`:
  - `game_state_t` enum, 3 bits.
  - Keycode constants KEY_ENTER = 8'h28, KEY_ESC = 8'h29.
  - Function `map_onehot(idx)`.
- Sub-module `key_edge` (parameter KEY_SLOTS, KEY), instantiated twice: slot compare, prev register, event pulse. Its prev register has a load-on-halt input.

## Test plan
- Reset, then idle 2 cycles -> MAIN_MENU; LD_MENU=1; LD_Map=0; Pause_En=0.
- Hold 8'h28 in slot 1 for 10 cycles -> one transition to PLAY; map_start pulses once; LD_Map=3'b001. Hold Enter through Reset -> stays in MAIN_MENU.
- In PLAY, press 8'h29 twice (release between) -> PAUSED, then PLAY; Pause_En 1 then 0; map_start stays low. `player_dead` asserted while PAUSED -> ignored.
- level_done in map 0, CLEAR_FRAMES=4 -> LEVEL_CLEAR for exactly 4 frame_ticks, then PLAY with map_idx=1, LD_Map=3'b010, and a map_start pulse.
- level_done on map 2 -> VICTORY after the banner; Enter -> MAIN_MENU; Enter -> PLAY with map_idx=0.
- level_done and player_dead in the same cycle in PLAY -> GAME_OVER; Reset asserted in GAME_OVER -> HALTED next cycle, with all outputs 0.
